move_input_ctrl: RTL and testbench
==================================

Name: move_input_ctrl

Overview:
- Front-end stage that sits directly upstream of the game logic and grid.
- Conditions the raw DE2 pushbuttons and switches into the clean 4-bit `move`, single-cycle `check` and single-cycle `start` the game consumes.
- Synchronises, debounces and edge-detects the buttons; latches the square code at the press; rejects codes outside 1..9 before they reach the grid.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles a button must hold a new level before it is accepted (10 ms at 50 MHz).
- DB_W, 20, width of each debounce counter; must satisfy 2^DB_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  synchronous active-low reset.
- sw_move  input  4  raw switch value, square code A1=1 .. C3=9.
- key_check  input  1  raw pushbutton, active-low (pressed = 0); commits a move.
- key_start  input  1  raw pushbutton, active-low; starts or restarts a game.
- move  output  4  latched square code, held stable between accepted presses.
- check  output  1  one-cycle pulse when a valid move is committed.
- start  output  1  one-cycle pulse on an accepted start press.
- move_err  output  1  one-cycle pulse when a press carried a code outside 1..9.
- busy  output  1  high while either button is debouncing or awaiting release.

Behaviour:
- Reset (rst=0 at a clk edge):
  - move=0, check=0, start=0, move_err=0, busy=0.
  - Synchronisers preset to released (1); counters cleared; both debounce FSMs go to IDLE.
  - Reset mid-debounce or mid-press discards the press; no pulse is ever emitted for it.
- Synchronisation:
  - sw_move, key_check and key_start each pass through a 2-flop synchroniser.
  - Only synchronised values are used downstream.
- Debounce FSM, one per button: states IDLE, PRESS_DB, HELD, RELEASE_DB.
  - IDLE: sync=0 -> PRESS_DB with counter cleared.
  - PRESS_DB: counter increments while sync=0. sync=1 returns to IDLE (glitch, no event). Counter reaching DEBOUNCE_CYCLES-1 -> HELD and raises a one-cycle accept strobe.
  - HELD: sync=1 -> RELEASE_DB with counter cleared.
  - RELEASE_DB: counter increments while sync=1. sync=0 returns to HELD. Counter reaching DEBOUNCE_CYCLES-1 -> IDLE.
  - Exactly one accept strobe per physical press, however long the button is held.
- Check path, on the cycle after the check accept strobe:
  - The synchronised sw_move is captured into move.
  - Code in 1..9: check=1 for exactly one cycle.
  - Code 0 or 10..15: move_err=1 for one cycle, check stays 0, move keeps its previous value.
- Start path: start=1 for exactly one cycle, the cycle after the start accept strobe. move is not altered.
- Latency from the raw falling edge to the output pulse: 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- Simultaneous accept strobes on the same cycle:
  - start wins and is emitted.
  - The check press is dropped entirely: no check, no move_err, move unchanged.
- Switch changes:
  - Changes while HELD, or between presses, never change move.
  - sw_move is sampled only at the accept point.
- busy = (check FSM != IDLE) or (start FSM != IDLE).
- Counter width: DB_W bits, saturating; never wraps within a debounce window.

Decomposition:
- Shared package holds:
  - Square codes A1..C3 = 4'd1..4'd9.
  - MOVE_MIN=1, MOVE_MAX=9.
  - Debounce state encoding: IDLE, PRESS_DB, HELD, RELEASE_DB.
- One sub-module, button_debounce: synchroniser, counter, FSM and accept-strobe output for a single active-low button.
  - Instantiated twice, for check and for start.
- Move latch, range check and arbitration stay in move_input_ctrl.

Test Plan (DEBOUNCE_CYCLES=4 for simulation):
- Valid press: reset, sw_move=5, key_check low for 20 cycles then high for 20 -> exactly one check pulse 7 cycles after the raw edge; move=5; move_err never high; busy returns to 0 after release debounce.
- Bounce: key_check toggles low/high every 2 cycles for 12 cycles, then settles low -> no pulse during the bounce; one check pulse after the stable window.
- Out-of-range code: sw_move=0, press -> move_err pulse, no check, move keeps prior value 5. Repeat with sw_move=12 -> same result.
- Long hold with switch change: press with sw_move=3, hold 100 cycles, change sw_move to 7 during the hold -> one check, move=3 until the next press.
- Collision: key_check and key_start fall on the same cycle -> one start pulse, no check, no move_err, move unchanged.
- Reset mid-press: assert rst=0 during PRESS_DB -> all outputs 0, no pulse after rst=1 until a fresh full press.

Source files
------------

// File: rtl/move_input_ctrl_pkg.sv
// Shared constants for the move input front-end: square codes, legal move
// range and the debounce FSM state encoding.
package move_input_ctrl_pkg;

    // Board square codes, row-major from A1 to C3
    localparam logic [3:0] SQ_A1 = 4'd1;
    localparam logic [3:0] SQ_A2 = 4'd2;
    localparam logic [3:0] SQ_A3 = 4'd3;
    localparam logic [3:0] SQ_B1 = 4'd4;
    localparam logic [3:0] SQ_B2 = 4'd5;
    localparam logic [3:0] SQ_B3 = 4'd6;
    localparam logic [3:0] SQ_C1 = 4'd7;
    localparam logic [3:0] SQ_C2 = 4'd8;
    localparam logic [3:0] SQ_C3 = 4'd9;

    localparam logic [3:0] MOVE_MIN = SQ_A1;
    localparam logic [3:0] MOVE_MAX = SQ_C3;

    // Debounce FSM states
    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] PRESS_DB   = 2'd1;
    localparam logic [1:0] HELD       = 2'd2;
    localparam logic [1:0] RELEASE_DB = 2'd3;

    function automatic logic move_in_range(input logic [3:0] code);
        return (code >= MOVE_MIN) && (code <= MOVE_MAX);
    endfunction

endpackage

// File: rtl/move_input_ctrl_button_debounce.sv
// Synchroniser, debounce counter and press/release FSM for one active-low
// pushbutton. Emits a single accept strobe per physical press.
module button_debounce
    import move_input_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DB_W            = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic accept,
    output logic busy
);

    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0] CNT_MAX  = '1;

    logic            sync1_q, sync2_q;
    logic [1:0]      state_q, state_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic [DB_W-1:0] cnt_inc;

    // Saturating increment so the counter can never wrap inside a window
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + DB_W'(1);

    // State registers; synchroniser presets to the released level
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; accept fires on the PRESS_DB -> HELD transition only
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!sync2_q) begin
                    state_d = PRESS_DB;
                    cnt_d   = '0;
                end
            end
            PRESS_DB: begin
                if (sync2_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    accept  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                if (sync2_q) begin
                    state_d = RELEASE_DB;
                    cnt_d   = '0;
                end
            end
            RELEASE_DB: begin
                if (!sync2_q) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: rtl/move_input_ctrl.sv
// Front-end between the DE2 buttons/switches and the game logic: debounces
// check and start, latches the square code at the check press and filters
// out codes that do not name a square.
module move_input_ctrl
    import move_input_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DB_W            = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_move,
    input  logic       key_check,
    input  logic       key_start,
    output logic [3:0] move,
    output logic       check,
    output logic       start,
    output logic       move_err,
    output logic       busy
);

    logic [3:0] sw_s1_q, sw_s2_q;
    logic [3:0] move_q, move_d;
    logic       check_q, check_d;
    logic       start_q, start_d;
    logic       err_q, err_d;
    logic       check_acc, start_acc;
    logic       check_busy, start_busy;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_W            (DB_W)
    ) u_check_db (
        .clk    (clk),
        .rst    (rst),
        .key    (key_check),
        .accept (check_acc),
        .busy   (check_busy)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_W            (DB_W)
    ) u_start_db (
        .clk    (clk),
        .rst    (rst),
        .key    (key_start),
        .accept (start_acc),
        .busy   (start_busy)
    );

    // Switch synchroniser plus the move latch and one-cycle output pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
            move_q  <= '0;
            check_q <= 1'b0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sw_s1_q <= sw_move;
            sw_s2_q <= sw_s1_q;
            move_q  <= move_d;
            check_q <= check_d;
            start_q <= start_d;
            err_q   <= err_d;
        end
    end

    // Arbitration: start beats a coincident check, which is then dropped
    always_comb begin
        move_d  = move_q;
        check_d = 1'b0;
        start_d = 1'b0;
        err_d   = 1'b0;
        if (start_acc) begin
            start_d = 1'b1;
        end else if (check_acc) begin
            if (move_in_range(sw_s2_q)) begin
                move_d  = sw_s2_q;
                check_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    assign move     = move_q;
    assign check    = check_q;
    assign start    = start_q;
    assign move_err = err_q;
    assign busy     = check_busy | start_busy;

endmodule

// File: tb/tb_move_input_ctrl.sv
// Directed bench for move_input_ctrl with a 4-cycle debounce window.
module tb_move_input_ctrl;

    localparam int LAT = 7;  // 2 sync + 4 debounce + 1 output register

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sw_move;
    logic       key_check, key_start;
    logic [3:0] move;
    logic       check, start, move_err, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_check, n_start, n_err;
    int last_check, last_start, last_err;
    int cyc0;

    always #5 clk = ~clk;

    move_input_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .DB_W            (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sw_move   (sw_move),
        .key_check (key_check),
        .key_start (key_start),
        .move      (move),
        .check     (check),
        .start     (start),
        .move_err  (move_err),
        .busy      (busy)
    );

    typedef struct {
        int         sel;       // 0 check, 1 start, 2 both together
        logic [3:0] sw;
        int         hold;
        int         exp_check;
        int         exp_start;
        int         exp_err;
        logic [3:0] exp_move;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (check) begin n_check++; last_check = cyc; end
        if (start) begin n_start++; last_start = cyc; end
        if (move_err) begin n_err++; last_err = cyc; end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_counts();
        n_check = 0; n_start = 0; n_err = 0;
        last_check = -1; last_start = -1; last_err = -1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        vecs[0] = '{0, 4'd5,  20, 1, 0, 0, 4'd5};
        vecs[1] = '{0, 4'd0,  20, 0, 0, 1, 4'd5};
        vecs[2] = '{0, 4'd12, 20, 0, 0, 1, 4'd5};
        vecs[3] = '{1, 4'd2,  12, 0, 1, 0, 4'd5};
        vecs[4] = '{0, 4'd9,  10, 1, 0, 0, 4'd9};
        vecs[5] = '{0, 4'd15, 10, 0, 0, 1, 4'd9};
        vecs[6] = '{2, 4'd8,  15, 0, 1, 0, 4'd9};
        vecs[7] = '{0, 4'd1,  8,  1, 0, 0, 4'd1};
        vecs[8] = '{0, 4'd10, 8,  0, 0, 1, 4'd1};

        rst = 1'b0; sw_move = 4'd0; key_check = 1'b1; key_start = 1'b1;
        clear_counts();
        ticks(3);
        chk("reset_move", move, 0);
        chk("reset_check", check, 0);
        chk("reset_start", start, 0);
        chk("reset_err", move_err, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b1;
        ticks(3);

        // Table of full press/release transactions
        for (int v = 0; v < 9; v++) begin
            sw_move = vecs[v].sw;
            ticks(3);
            clear_counts();
            cyc0 = cyc;
            if (vecs[v].sel != 1) key_check = 1'b0;
            if (vecs[v].sel != 0) key_start = 1'b0;
            ticks(vecs[v].hold);
            key_check = 1'b1;
            key_start = 1'b1;
            ticks(20);
            chk($sformatf("v%0d_checks", v), n_check, vecs[v].exp_check);
            chk($sformatf("v%0d_starts", v), n_start, vecs[v].exp_start);
            chk($sformatf("v%0d_errs", v), n_err, vecs[v].exp_err);
            chk($sformatf("v%0d_move", v), move, vecs[v].exp_move);
            chk($sformatf("v%0d_busy_end", v), busy, 0);
            if (vecs[v].exp_check == 1)
                chk($sformatf("v%0d_check_lat", v), last_check - cyc0, LAT);
            if (vecs[v].exp_start == 1)
                chk($sformatf("v%0d_start_lat", v), last_start - cyc0, LAT);
            if (vecs[v].exp_err == 1)
                chk($sformatf("v%0d_err_lat", v), last_err - cyc0, LAT);
        end

        // Bounce: 2-cycle low/high chatter, then a stable press
        sw_move = 4'd4;
        ticks(3);
        clear_counts();
        for (int i = 0; i < 6; i++) begin
            key_check = (i % 2 == 0) ? 1'b0 : 1'b1;
            ticks(2);
        end
        chk("bounce_no_check", n_check, 0);
        chk("bounce_no_err", n_err, 0);
        cyc0 = cyc;
        key_check = 1'b0;
        ticks(20);
        key_check = 1'b1;
        ticks(20);
        chk("bounce_checks", n_check, 1);
        chk("bounce_lat", last_check - cyc0, LAT);
        chk("bounce_move", move, 4);

        // Long hold with the switch changing mid-hold
        sw_move = 4'd3;
        ticks(3);
        clear_counts();
        key_check = 1'b0;
        ticks(50);
        sw_move = 4'd7;
        ticks(50);
        chk("hold_move_during", move, 3);
        key_check = 1'b1;
        ticks(30);
        chk("hold_checks", n_check, 1);
        chk("hold_move_after", move, 3);
        chk("hold_errs", n_err, 0);

        // Reset in the middle of PRESS_DB
        sw_move = 4'd6;
        ticks(3);
        clear_counts();
        key_check = 1'b0;
        ticks(4);
        chk("midpress_busy", busy, 1);
        rst = 1'b0;
        key_check = 1'b1;
        ticks(2);
        chk("midrst_move", move, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_outs", {check, start, move_err}, 0);
        rst = 1'b1;
        ticks(20);
        chk("postrst_checks", n_check, 0);
        chk("postrst_errs", n_err, 0);
        chk("postrst_busy", busy, 0);
        cyc0 = cyc;
        key_check = 1'b0;
        ticks(10);
        key_check = 1'b1;
        ticks(20);
        chk("fresh_checks", n_check, 1);
        chk("fresh_lat", last_check - cyc0, LAT);
        chk("fresh_move", move, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
